rca_share_arbiter: RTL
======================

// Module: rca_share_arbiter
// PURPOSE
//  Shares one N-bit ripple-carry adder (RCA) between two requesters with round-robin arbitration.
//  Registers the granted operands and holds them stable on the RCA for SETTLE cycles so the carry can ripple.
//  Then captures {Cout,S,P} and returns it with the requester id over a valid/ready response channel.
//  Sits between operand producers and the combinational RCA in the dynamic-adder datapath.
// PARAMETERS
//  N       16  operand/sum width, passed to the RCA
//  SETTLE  3   cycles the operands are held on the RCA before capture; legal range >=1
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  req0_valid in   1  requester 0 has an operation
//  req0_ready out  1  requester 0 accepted this cycle
//  req0_A     in   N  requester 0 operand A
//  req0_B     in   N  requester 0 operand B
//  req0_Cin   in   1  requester 0 carry-in
//  req1_*     --   -  identical set for requester 1
//  rsp_valid  out  1  response holds a result
//  rsp_ready  in   1  consumer takes the response
//  rsp_id     out  1  requester the result belongs to
//  rsp_S      out  N  sum
//  rsp_Cout   out  1  carry-out
//  rsp_P      out  N  propagate vector from the RCA
// BEHAVIOUR
//  - Reset (sync, active-high): one cycle of rst forces the following:
//    - state=IDLE, cnt=0, rsp_valid=0, rsp_id=0, rsp_S=0, rsp_Cout=0, rsp_P=0.
//    - Operand registers are cleared to 0; both reqX_ready=0.
//    - last_grant=1, so requester 0 wins the first tie.
//  - rst during SETTLE or RESP abandons the operation: no response and no ready.
//  - rst has priority over every other event.
//  - FSM states:
//    - IDLE: reqX_ready is combinational and high only for the granted requester.
//      - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one != last_grant.
//      - On a handshake edge: latch A/B/Cin/id, set last_grant=id, cnt=SETTLE-1, go to SETTLE.
//    - SETTLE: both ready=0; the RCA sees only the latched operands.
//      - While cnt!=0: cnt decrements each cycle.
//      - When cnt==0: capture {Cout,S,P} and id into the rsp regs, set rsp_valid=1, go to RESP.
//    - RESP: rsp_* stay stable while rsp_valid&&!rsp_ready.
//      - On rsp_valid&&rsp_ready: rsp_valid=0 and go to IDLE.
//      - No accept happens in this same cycle.
//  - Latency: rsp_valid rises exactly SETTLE edges after the accept edge.
//  - Throughput: at most one operation per SETTLE+2 cycles.
//  - Arithmetic: {rsp_Cout,rsp_S} == A+B+Cin, taken mod 2^(N+1). All-ones+all-ones+1 gives Cout=1, S=all-ones.
//  - A requester may drop valid before it is granted; no accept happens for it.
//  - Operands are sampled only on the handshake edge. Later input changes have no effect on the result.
// STRUCTURE
//  - Package rca_arb_pkg holds:
//    - state enum {IDLE,SETTLE,RESP};
//    - the id width localparam (1);
//    - SETTLE_MIN=1.
//  - One sub-module: the existing RCA #(.N(N)), instantiated internally and driven by the operand registers.
//  - Arbiter, counter and FSM sit in this module.
// TESTING
//  - Single op: req0 A=0x00FF B=0x0001 Cin=0.
//    -> rsp_valid 3 edges after accept; S=0x0100, Cout=0, id=0.
//  - Overflow: req1 A=0xFFFF B=0xFFFF Cin=1.
//    -> S=0xFFFF, Cout=1, id=1.
//  - Tie from reset, both valid continuously.
//    -> grant order is 0,1,0,1; rsp_id alternates.
//  - Backpressure: hold rsp_ready=0 for 5 cycles.
//    -> rsp_* stay stable and neither ready rises; after rsp_ready=1, the next accept comes one cycle later.
//  - Reset mid-SETTLE: assert rst at cnt=1.
//    -> rsp_valid stays 0, state is IDLE, and the next tie grants req0.
//  - Random: 10000 ops, both requesters, random valid/ready, seed 42.
//    -> every response equals A+B+Cin for its id, in grant order, with no loss or duplication.

Source files
------------

// File: rtl/rca_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : rca_arb_pkg                                                 |
// | Shared types and constants for the shared-RCA round-robin arbiter.    |
// | Contents: FSM state enum, requester-id width, minimum settle time.    |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package rca_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   localparam int ID_W       = 1;
   localparam int SETTLE_MIN = 1;

endpackage : rca_arb_pkg
`default_nettype wire

// File: rtl/rca_share_arbiter_rca.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rca                                                         |
// | Purely combinational N-bit ripple-carry adder.                        |
// | Ports   : a, b   - N-bit operands                                     |
// |           cin    - carry-in                                           |
// |           s      - N-bit sum                                          |
// |           cout   - carry-out of the top bit                           |
// |           p      - per-bit propagate vector (a ^ b)                   |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module rca #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout,
   output logic [N-1:0] p
);

   logic [N:0]   w_c;
   logic [N-1:0] w_p;

   assign w_c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign w_p[i]   = a[i] ^ b[i];
      assign s[i]     = w_p[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_p[i] & w_c[i]);
   end

   assign p    = w_p;
   assign cout = w_c[N];

endmodule : rca
`default_nettype wire

// File: rtl/rca_share_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rca_share_arbiter                                           |
// | Shares one ripple-carry adder between two requesters. A round-robin   |
// | arbiter accepts one operation, the operands are held on the adder for |
// | SETTLE cycles, then {cout,s,p} and the requester id are returned on a |
// | valid/ready response channel.                                         |
// | Ports   : clk, rst             - clock, synchronous active-high reset |
// |           req0_* / req1_*      - valid/ready + A, B, Cin per requester|
// |           rsp_valid/rsp_ready  - response handshake                   |
// |           rsp_id, rsp_S,                                              |
// |           rsp_Cout, rsp_P      - result and owning requester          |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module rca_share_arbiter
   import rca_arb_pkg::*;
#(
   parameter int N      = 16,
   parameter int SETTLE = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_A,
   input  logic [N-1:0] req0_B,
   input  logic         req0_Cin,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_A,
   input  logic [N-1:0] req1_B,
   input  logic         req1_Cin,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_S,
   output logic         rsp_Cout,
   output logic [N-1:0] rsp_P
);

   // An out-of-range SETTLE is clamped to the shortest legal hold time.
   localparam int c_settle_eff = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
   localparam int c_cnt_w      = (c_settle_eff > 1) ? $clog2(c_settle_eff) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_settle_eff - 1);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [ID_W-1:0]   r_last_grant;

   logic [N-1:0]      r_a;
   logic [N-1:0]      r_b;
   logic              r_cin;
   logic [ID_W-1:0]   r_id;

   logic              r_rsp_valid;
   logic [ID_W-1:0]   r_rsp_id;
   logic [N-1:0]      r_rsp_s;
   logic              r_rsp_cout;
   logic [N-1:0]      r_rsp_p;

   logic [ID_W-1:0]   w_grant_id;
   logic              w_any_valid;
   logic              w_accept;
   logic              w_capture;
   logic              w_rsp_take;
   logic [N-1:0]      w_sel_a;
   logic [N-1:0]      w_sel_b;
   logic              w_sel_cin;

   logic [N-1:0]      w_rca_s;
   logic              w_rca_cout;
   logic [N-1:0]      w_rca_p;

   // Round robin: a lone requester always wins; on a tie the one that
   // did not win last time is chosen.
   assign w_any_valid = req0_valid | req1_valid;
   assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant
                      : (req1_valid ? ID_W'(1) : ID_W'(0));

   assign w_sel_a   = (w_grant_id == ID_W'(1)) ? req1_A   : req0_A;
   assign w_sel_b   = (w_grant_id == ID_W'(1)) ? req1_B   : req0_B;
   assign w_sel_cin = (w_grant_id == ID_W'(1)) ? req1_Cin : req0_Cin;

   // The adder only ever sees the registered operands, so requester
   // inputs can change freely once an operation has been accepted.
   rca #(.N(N)) u_rca (
      .a    (r_a),
      .b    (r_b),
      .cin  (r_cin),
      .s    (w_rca_s),
      .cout (w_rca_cout),
      .p    (w_rca_p)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_rsp_take  = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Ready is withheld during reset so no handshake is seen on
            // an edge that the reset will override.
            if (w_any_valid && !rst) begin
               req0_ready  = (w_grant_id == ID_W'(0));
               req1_ready  = (w_grant_id == ID_W'(1));
               w_accept    = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_take  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_last_grant <= ID_W'(1);
         r_a          <= '0;
         r_b          <= '0;
         r_cin        <= 1'b0;
         r_id         <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_s      <= '0;
         r_rsp_cout   <= 1'b0;
         r_rsp_p      <= '0;
      end else begin
         if (w_accept) begin
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_cin        <= w_sel_cin;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_cnt        <= c_cnt_load;
         end else if ((r_state == ST_SETTLE) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
         end

         if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_s     <= w_rca_s;
            r_rsp_cout  <= w_rca_cout;
            r_rsp_p     <= w_rca_p;
         end else if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_S     = r_rsp_s;
   assign rsp_Cout  = r_rsp_cout;
   assign rsp_P     = r_rsp_p;

endmodule : rca_share_arbiter
`default_nettype wire
